// File: rtl/can_btl_pkg.sv
// Shared types and constants for the CAN bit-timing logic: segment encoding,
// default port widths and bus level names.
package can_btl_pkg;

  localparam int SEGW_DEF = 4;
  localparam int SJWW_DEF = 2;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  typedef enum logic [1:0] {
    SEG_IDLE  = 2'd0,
    SEG_SYNC  = 2'd1,
    SEG_TSEG1 = 2'd2,
    SEG_TSEG2 = 2'd3
  } seg_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input, with one-CLK rise/fall
// pulses derived from the synchronised level.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s_p0, s_p1, s_p2;

  // p0/p1 resolve metastability, p2 holds the previous synchronised level
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s_p0 <= RST_VAL;
      s_p1 <= RST_VAL;
      s_p2 <= RST_VAL;
    end else begin
      s_p0 <= d;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  assign q    = s_p1;
  assign rise = s_p1 & ~s_p2;
  assign fall = ~s_p1 & s_p2;

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing state machine: SYNC/TSEG1/TSEG2 segmentation, hard sync and
// SJW-limited resync. Define CAN_BTL_TRIPLE_SAMPLE_EN for 3-sample majority voting.
module can_bit_timing
  import can_btl_pkg::*;
#(
  parameter int SEGW = SEGW_DEF,
  parameter int SJWW = SJWW_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            tq_clk,
  input  logic            enable,
  input  logic            rx,
  input  logic            hard_sync_en,
  input  logic [SEGW-1:0] tseg1,
  input  logic [SEGW-1:0] tseg2,
  input  logic [SJWW-1:0] sjw,
  output logic            sample_point,
  output logic            tx_point,
  output logic            rx_sampled,
  output logic [1:0]      seg
);

  logic tq_tick, rx_q, rx_fall;
  logic sync_unused_tq_q, sync_unused_tq_fall, sync_unused_rx_rise;

  sync_edge_det #(.RST_VAL(1'b0)) u_tq_sync (
    .CLK(CLK), .RST_N(RST_N), .d(tq_clk),
    .q(sync_unused_tq_q), .rise(tq_tick), .fall(sync_unused_tq_fall)
  );

  sync_edge_det #(.RST_VAL(RECESSIVE)) u_rx_sync (
    .CLK(CLK), .RST_N(RST_N), .d(rx),
    .q(rx_q), .rise(sync_unused_rx_rise), .fall(rx_fall)
  );

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  seg_t            seg_q, seg_n;
  logic [SEGW-1:0] cnt, cnt_n, ext, ext_n, shorten, shorten_n;
  logic [SEGW-1:0] t1, t1_n, t2, t2_n, sjw_l, sjw_n, sjw_ext;
  logic            resync_done, rd_n, edge_pend, ep_n;
  logic            rxs_q, rxs_n, sp_q, sp_n, tx_q, tx_n;
  logic            edge_seen, resync_ok, end1, end2, jump2, rx_vote;
  logic [SEGW-1:0] ext_eff, sh_eff;

  assign sjw_ext   = SEGW'(sjw) + SEGW'(1);
  // an edge arriving in the same CLK as the tick is treated as already pending
  assign edge_seen = edge_pend | rx_fall;
  assign resync_ok = edge_seen & ~resync_done & (rxs_q == RECESSIVE);
  assign ext_eff   = (resync_ok && seg_q == SEG_TSEG1) ? ((cnt < sjw_l) ? cnt : sjw_l) : ext;
  assign sh_eff    = (resync_ok && seg_q == SEG_TSEG2) ? sjw_l : shorten;
  assign end1      = {1'b0, cnt} >= ({1'b0, t1} + {1'b0, ext_eff});
  // T2 - shorten and T2 - cnt + 1 rearranged as additions to avoid underflow
  assign end2      = ({1'b0, cnt} + {1'b0, sh_eff}) >= {1'b0, t2};
  assign jump2     = ({1'b0, t2} + (SEGW+1)'(1)) <= ({1'b0, cnt} + {1'b0, sjw_l});

`ifdef CAN_BTL_TRIPLE_SAMPLE_EN
  logic [1:0] hist, hist_n;
  assign rx_vote = maj3(hist[1], hist[0], rx_q);
`else
  assign rx_vote = maj3(rx_q, rx_q, rx_q);
`endif

  always_comb begin
    seg_n     = seg_q;
    cnt_n     = cnt;
    ext_n     = ext;
    shorten_n = shorten;
    t1_n      = t1;
    t2_n      = t2;
    sjw_n     = sjw_l;
    rd_n      = resync_done;
    ep_n      = edge_seen;
    rxs_n     = rxs_q;
    sp_n      = 1'b0;
    tx_n      = 1'b0;
`ifdef CAN_BTL_TRIPLE_SAMPLE_EN
    hist_n    = hist;
    if (tq_tick && seg_q == SEG_TSEG1) hist_n = {hist[0], rx_q};
    if (tq_tick && seg_q != SEG_TSEG1) hist_n = {RECESSIVE, RECESSIVE};
`endif
    if (!enable) begin
      seg_n     = SEG_IDLE;
      cnt_n     = '0;
      ext_n     = '0;
      shorten_n = '0;
      rd_n      = 1'b0;
      ep_n      = 1'b0;
    end else if (tq_tick) begin
      ep_n = 1'b0;
      if (seg_q == SEG_IDLE) begin
        seg_n = SEG_SYNC;
        tx_n  = 1'b1;
        t1_n  = tseg1;
        t2_n  = tseg2;
        sjw_n = sjw_ext;
      end else if (edge_seen && hard_sync_en) begin
        seg_n     = SEG_TSEG1;
        cnt_n     = SEGW'(1);
        ext_n     = '0;
        shorten_n = '0;
        rd_n      = 1'b0;
        tx_n      = 1'b1;
        t1_n      = tseg1;
        t2_n      = tseg2;
        sjw_n     = sjw_ext;
      end else begin
        if (resync_ok) rd_n = 1'b1;
        case (seg_q)
          SEG_SYNC: begin
            seg_n = SEG_TSEG1;
            cnt_n = SEGW'(1);
          end
          SEG_TSEG1: begin
            ext_n = ext_eff;
            if (end1) begin
              seg_n = SEG_TSEG2;
              cnt_n = SEGW'(1);
              sp_n  = 1'b1;
              rxs_n = rx_vote;
              rd_n  = 1'b0;
            end else begin
              cnt_n = cnt + SEGW'(1);
            end
          end
          SEG_TSEG2: begin
            if (resync_ok && jump2) begin
              seg_n     = SEG_TSEG1;
              cnt_n     = SEGW'(1);
              ext_n     = '0;
              shorten_n = '0;
              tx_n      = 1'b1;
            end else begin
              shorten_n = sh_eff;
              if (end2) begin
                seg_n     = SEG_SYNC;
                ext_n     = '0;
                shorten_n = '0;
                tx_n      = 1'b1;
                t1_n      = tseg1;
                t2_n      = tseg2;
                sjw_n     = sjw_ext;
              end else begin
                cnt_n = cnt + SEGW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      seg_q       <= SEG_IDLE;
      cnt         <= '0;
      ext         <= '0;
      shorten     <= '0;
      resync_done <= 1'b0;
      edge_pend   <= 1'b0;
      rxs_q       <= RECESSIVE;
      sp_q        <= 1'b0;
      tx_q        <= 1'b0;
`ifdef CAN_BTL_TRIPLE_SAMPLE_EN
      hist        <= {RECESSIVE, RECESSIVE};
`endif
    end else begin
      seg_q       <= seg_n;
      cnt         <= cnt_n;
      ext         <= ext_n;
      shorten     <= shorten_n;
      resync_done <= rd_n;
      edge_pend   <= ep_n;
      rxs_q       <= rxs_n;
      sp_q        <= sp_n;
      tx_q        <= tx_n;
`ifdef CAN_BTL_TRIPLE_SAMPLE_EN
      hist        <= hist_n;
`endif
    end
  end

  // configuration shadow registers are only read outside IDLE, after a load
  always_ff @(posedge CLK) begin
    t1    <= t1_n;
    t2    <= t2_n;
    sjw_l <= sjw_n;
  end

  assign sample_point = sp_q;
  assign tx_point     = tx_q;
  assign rx_sampled   = rxs_q;
  assign seg          = seg_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing: tq = 8 CLK, T1=5, T2=3, SJW=2; bit lengths
// are measured as CLK distances between strobes (8 CLK per tq).
module tb_can_bit_timing;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       tq_clk = 1'b0;
  logic       enable = 1'b0;
  logic       rx = 1'b1;
  logic       hard_sync_en = 1'b0;
  logic [3:0] tseg1 = 4'd5;
  logic [3:0] tseg2 = 4'd3;
  logic [1:0] sjw = 2'd1;
  logic       sample_point, tx_point, rx_sampled;
  logic [1:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

  can_bit_timing dut (
    .CLK(CLK), .RST_N(RST_N), .tq_clk(tq_clk), .enable(enable), .rx(rx),
    .hard_sync_en(hard_sync_en), .tseg1(tseg1), .tseg2(tseg2), .sjw(sjw),
    .sample_point(sample_point), .tx_point(tx_point), .rx_sampled(rx_sampled),
    .seg(seg)
  );

  always #5 CLK = ~CLK;
  always #40 tq_clk = ~tq_clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!tx_point && n < 400);
    if (!tx_point) n = -1;
  endtask

  task automatic wait_sp(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!sample_point && n < 400);
    if (!sample_point) n = -1;
  endtask

  // Called at a tx_point; pulses rx dominant during tq frame j1 (and j2 if >0),
  // then returns the CLK count to the next tx_point.
  task automatic bit_with_edges(input int j1, input int j2, output int len);
    int t, n;
    t = 0;
    if (j1 > 0) begin
      cyc(8 * j1 + 2 - t); rx = 1'b0; cyc(2); rx = 1'b1; t = 8 * j1 + 4;
    end
    if (j2 > 0) begin
      cyc(8 * j2 + 2 - t); rx = 1'b0; cyc(2); rx = 1'b1; t = 8 * j2 + 4;
    end
    wait_tx(n);
    len = (n < 0) ? -1 : t + n;
  endtask

  task automatic test_reset;
    cyc(3);
    n_cmp++; if (seg !== 2'd0) begin n_bad++; $display("FAIL reset_seg: got %0d want 0", seg); end
    n_cmp++; if (rx_sampled !== 1'b1) begin n_bad++; $display("FAIL reset_rx_sampled: got %b want 1", rx_sampled); end
    n_cmp++; if (sample_point !== 1'b0) begin n_bad++; $display("FAIL reset_sp: got %b want 0", sample_point); end
    n_cmp++; if (tx_point !== 1'b0) begin n_bad++; $display("FAIL reset_tx: got %b want 0", tx_point); end
    RST_N = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_no_edges;
    int n;
    wait_tx(n);
    n_cmp++; if (n < 1 || n > 12) begin n_bad++; $display("FAIL first_sync: got %0d cycles want 1..12", n); end
    n_cmp++; if (seg !== 2'd1) begin n_bad++; $display("FAIL first_sync_seg: got %0d want 1", seg); end
    for (int i = 0; i < 3; i++) begin
      wait_sp(n);
      n_cmp++; if (n !== 48) begin n_bad++; $display("FAIL nominal_sp bit%0d: got %0d want 48", i, n); end
      n_cmp++; if (rx_sampled !== 1'b1) begin n_bad++; $display("FAIL nominal_rx bit%0d: got %b want 1", i, rx_sampled); end
      wait_tx(n);
      n_cmp++; if (n !== 24) begin n_bad++; $display("FAIL nominal_tx bit%0d: got %0d want 24", i, n); end
    end
  endtask

  task automatic test_hard_sync;
    int n;
    wait_tx(n);
    hard_sync_en = 1'b1;
    bit_with_edges(7, 0, n);
    n_cmp++; if (n !== 64) begin n_bad++; $display("FAIL hard_sync_len: got %0d want 64", n); end
    n_cmp++; if (seg !== 2'd2) begin n_bad++; $display("FAIL hard_sync_seg: got %0d want 2", seg); end
    hard_sync_en = 1'b0;
    wait_sp(n);
    n_cmp++; if (n !== 40) begin n_bad++; $display("FAIL hard_sync_sp: got %0d want 40", n); end
  endtask

  task automatic test_resync_tseg1;
    int n;
    wait_tx(n);
    bit_with_edges(1, 0, n);
    n_cmp++; if (n !== 80) begin n_bad++; $display("FAIL resync_t1_cnt1: got %0d want 80", n); end
    bit_with_edges(4, 0, n);
    n_cmp++; if (n !== 88) begin n_bad++; $display("FAIL resync_t1_clamp: got %0d want 88", n); end
  endtask

  task automatic test_resync_tseg2;
    int n;
    wait_tx(n);
    bit_with_edges(8, 0, n);
    n_cmp++; if (n !== 72) begin n_bad++; $display("FAIL resync_t2_jump_at: got %0d want 72", n); end
    n_cmp++; if (seg !== 2'd2) begin n_bad++; $display("FAIL resync_t2_jump_seg: got %0d want 2", seg); end
    wait_tx(n);
    n_cmp++; if (n !== 64) begin n_bad++; $display("FAIL resync_t2_jump_len: got %0d want 64", n); end
    bit_with_edges(6, 0, n);
    n_cmp++; if (n !== 56) begin n_bad++; $display("FAIL resync_t2_shorten: got %0d want 56", n); end
  endtask

  task automatic test_ignored_edges;
    int n;
    wait_tx(n);
    bit_with_edges(1, 3, n);
    n_cmp++; if (n !== 80) begin n_bad++; $display("FAIL second_edge: got %0d want 80", n); end
    cyc(10); rx = 1'b0;
    wait_sp(n);
    n_cmp++; if (n + 10 !== 56) begin n_bad++; $display("FAIL dominant_sp: got %0d want 56", n + 10); end
    n_cmp++; if (rx_sampled !== 1'b0) begin n_bad++; $display("FAIL dominant_rx: got %b want 0", rx_sampled); end
    cyc(4); rx = 1'b1;
    wait_tx(n);
    n_cmp++; if (n + 4 !== 24) begin n_bad++; $display("FAIL dominant_tx: got %0d want 24", n + 4); end
    bit_with_edges(1, 0, n);
    n_cmp++; if (n !== 72) begin n_bad++; $display("FAIL edge_after_dominant: got %0d want 72", n); end
    wait_sp(n);
    n_cmp++; if (rx_sampled !== 1'b1) begin n_bad++; $display("FAIL recessive_again: got %b want 1", rx_sampled); end
  endtask

  task automatic test_reset_mid_bit;
    int n;
    wait_tx(n);
    cyc(10); rx = 1'b0;
    wait_sp(n);
    cyc(2); rx = 1'b1;
    n_cmp++; if (rx_sampled !== 1'b0) begin n_bad++; $display("FAIL pre_reset_rx: got %b want 0", rx_sampled); end
    wait_tx(n);
    cyc(20);
    n_cmp++; if (seg !== 2'd2) begin n_bad++; $display("FAIL pre_reset_seg: got %0d want 2", seg); end
    RST_N = 1'b0;
    cyc(1);
    RST_N = 1'b1;
    n_cmp++; if (seg !== 2'd0) begin n_bad++; $display("FAIL mid_reset_seg: got %0d want 0", seg); end
    n_cmp++; if (rx_sampled !== 1'b1) begin n_bad++; $display("FAIL mid_reset_rx: got %b want 1", rx_sampled); end
    n_cmp++; if (sample_point !== 1'b0 || tx_point !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_strobes: got sp=%b tx=%b want 0 0", sample_point, tx_point);
    end
    wait_tx(n);
    n_cmp++; if (n < 1 || n > 12) begin n_bad++; $display("FAIL resume_sync: got %0d cycles want 1..12", n); end
    n_cmp++; if (seg !== 2'd1) begin n_bad++; $display("FAIL resume_seg: got %0d want 1", seg); end
  endtask

  task automatic test_disable;
    int strobes;
    strobes = 0;
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (sample_point || tx_point) strobes++;
    end
    n_cmp++; if (seg !== 2'd0) begin n_bad++; $display("FAIL disable_seg: got %0d want 0", seg); end
    n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL disable_strobes: got %0d want 0", strobes); end
  endtask

  initial begin
    test_reset();
    test_no_edges();
    test_hard_sync();
    test_resync_tseg1();
    test_resync_tseg2();
    test_ignored_edges();
    test_reset_mid_bit();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Downstream of the clock divider: consumes the divider's scaled clock (one rising edge = one time quantum, tq) and runs the CAN bit-timing state machine.
- Segments each bit into SYNC / TSEG1 (prop+phase1) / TSEG2 (phase2).
- Applies hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges of RX.
- Emits sample-point and transmit-point strobes plus the sampled bit to the bit-stream processor.

Parameters:
- SEGW, 4, width of segment-length config ports and tq counter
- SJWW, 2, width of sjw port

Ports:
- CLK  in  1  system clock (100 MHz)
- RST_N  in  1  synchronous active-low reset
- tq_clk  in  1  scaled clock from the divider; each rising edge = one tq
- enable  in  1  bit timing active
- rx  in  1  CAN bus receive line (1 = recessive), asynchronous
- hard_sync_en  in  1  next edge is a hard sync (bus idle / SOF)
- tseg1  in  SEGW  prop_seg + phase_seg1 in tq, legal 2..15
- tseg2  in  SEGW  phase_seg2 in tq, legal 2..8
- sjw  in  SJWW  resync jump width minus 1 (sjw+1 = 1..4 tq)
- sample_point  out  1  one-CLK strobe at the sample point
- tx_point  out  1  one-CLK strobe at bit start (SYNC entry)
- rx_sampled  out  1  bit value captured at the last sample point
- seg  out  2  current segment: 0 IDLE, 1 SYNC, 2 TSEG1, 3 TSEG2

Behaviour:
- Reset values: sample_point=0, tx_point=0, rx_sampled=1, seg=IDLE; cnt, ext, shorten, resync_done and edge_pend all cleared.
- tq_clk and rx each pass through a 2-FF synchroniser.
  - tq_tick = rising edge of synchronised tq_clk, one CLK wide.
  - rx_edge = synchronised rx going 1→0; it sets edge_pend, which holds until the next tq_tick consumes it.
- enable=0: force IDLE, clear all state; strobes stay 0.
- IDLE with enable=1: on the next tq_tick, enter SYNC and pulse tx_point.
- tseg1, tseg2 and sjw are latched into T1, T2 and SJW (= sjw+1) on every SYNC entry and on every hard sync. They never change mid-bit.
- Normal tq_tick transitions (strobes pulse in the same CLK as the transition):
  - SYNC → TSEG1, cnt=1.
  - TSEG1: if cnt ≥ T1+ext → TSEG2, cnt=1, pulse sample_point, rx_sampled ← synchronised rx, clear resync_done. Otherwise cnt++.
  - TSEG2: if cnt ≥ T2−shorten → SYNC, ext=0, shorten=0, pulse tx_point. Otherwise cnt++.
- Edge handling on a tq_tick with edge_pend set. Priority: hard sync > resync > normal. edge_pend is cleared either way.
  - Hard sync (hard_sync_en=1, any non-IDLE state): → TSEG1, cnt=1, ext=shorten=0, resync_done=0, pulse tx_point.
  - Resync is allowed only if resync_done=0 and rx_sampled=1. If allowed, set resync_done=1, then by state:
    - SYNC: phase error 0; no correction.
    - TSEG1: ext = min(cnt, SJW); the TSEG1 end test uses the new ext in the same tick.
    - TSEG2, with r = T2−cnt+1: if r ≤ SJW → TSEG1, cnt=1, pulse tx_point. Otherwise shorten=SJW and apply the normal TSEG2 end test.
  - Resync not allowed: the edge is ignored.
- Arithmetic: cnt, ext and shorten are SEGW bits wide. T1+ext is evaluated at SEGW+1 bits, so there is no wrap.
- Reset mid-bit: applies on the next CLK edge; the output values above hold regardless of tq_tick.

Optional Feature:
- Macro: CAN_BTL_TRIPLE_SAMPLE_EN.
- Defined: keep the synchronised rx sampled on the last three tq_ticks of TSEG1; rx_sampled = majority of those three.
- Undefined: single sample at the sample point.
- Strobe timing is identical either way.

Decomposition:
- Package can_btl_pkg holds:
  - segment enum (IDLE/SYNC/TSEG1/TSEG2) and its 2-bit encoding
  - SEGW/SJWW defaults
  - recessive/dominant constants
- One sub-module, sync_edge_det: 2-FF synchroniser plus rise/fall pulse outputs, instanced for tq_clk and for rx.

Test Plan:
Common setup: tq_clk period 8 CLK, T1=5 (tseg1=5), T2=3 (tseg2=3), SJW=2 (sjw=1), rx=1.
1. No edges → tx_point every 9 tq; sample_point exactly 6 tq after each tx_point; rx_sampled=1.
2. hard_sync_en=1, rx 1→0 during TSEG2 cnt=2 → next tq_tick: seg=TSEG1 with tx_point; sample_point 5 tq later.
3. Resync in TSEG1:
   - edge at cnt=1 → that bit is 10 tq long;
   - separate bit, edge at cnt=4 → ext clamps to 2, bit is 11 tq long.
4. Resync in TSEG2:
   - edge at cnt=3 (r=1) → immediate TSEG1 with tx_point, bit is 8 tq;
   - edge at cnt=1 (r=3) → shorten=2, bit is 7 tq.
5. Ignored edges:
   - second edge in the same bit after a resync → no timing change;
   - edge while rx_sampled=0 → no timing change.
6. RST_N low for one CLK while in TSEG1 → next CLK: seg=IDLE, rx_sampled=1, no strobes; with enable=1, SYNC resumes on the following tq_tick.
